fp16_add_seq: RTL and testbench

- Multi-cycle sequencer for one half-precision (FP16) floating-point add/subtract.
- Fetches two operands byte-by-byte from the shared byte-wide data memory and computes the sum.
- Steps the sum through align, add and normalize states, then writes it back and raises done.
- Sits beside the data memory as the hardware float-add engine. It owns the memory port only while busy.

---
 rtl/fp16_add_seq_if.sv | 26 ++
 rtl/fp16_add_seq.sv | 183 ++++++++++++++++++
 tb/tb_fp16_add_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fp16_add_seq_if.sv
// Handshake and byte-wide memory port between fp16_add_seq and its host/memory.
//   start       : host -> engine, single-cycle request
//   busy, done  : engine status
//   mem_addr    : engine byte address
//   mem_rd_data : memory -> engine, registered read data
//   mem_wr_en   : engine write strobe
//   mem_wr_data : engine write data
interface fp16_add_seq_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  modport master (
    output start, mem_rd_data,
    input  busy, done, mem_addr, mem_wr_en, mem_wr_data
  );

  modport slave (
    input  start, mem_rd_data,
    output busy, done, mem_addr, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/fp16_add_seq.sv
// Multi-cycle FP16 adder: reads A and B byte-wise from data memory, aligns,
// adds, normalizes and writes the sum back, then raises done.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   bus        : slave side of fp16_add_seq_if (start/busy/done + memory port)
module fp16_add_seq #(
  parameter int unsigned OP_BASE   = 128,
  parameter int unsigned ALIGN_CAP = 12
) (
  input  logic         clk,
  input  logic         reset,
  fp16_add_seq_if.slave bus
);

  localparam int unsigned MW = 12;
  localparam int unsigned EW = 7;
  localparam logic [7:0]  BASE8 = 8'(OP_BASE);
  localparam logic [4:0]  CAP5  = 5'(ALIGN_CAP);
  localparam logic [3:0]  CAP4  = 4'(ALIGN_CAP);

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, RD3, RDW, UNPACK, ALIGN, ADD, NORM, PACK, WRH, WRL, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            a_q, a_d, b_q, b_d;
  logic                   sx_q, sx_d, sy_q, sy_d;
  logic signed [EW-1:0]   ex_q, ex_d;
  logic [MW-1:0]          mx_q, mx_d, my_q, my_d;
  logic [3:0]             d_q, d_d;
  logic [7:0]             res_lo_q, res_lo_d;
  logic                   busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d;
  logic [7:0]             addr_q, addr_d, wr_data_q, wr_data_d;

  // Operand unpack: hidden bit restored, e=0 flushes to zero
  logic [4:0]    ea, eb, ex_u, ey_u, diff;
  logic [MW-1:0] ma, mb, sum_m;
  logic          swap;
  logic [3:0]    d_un;
  logic [15:0]   packed_res;

  assign ea   = a_q[14:10];
  assign eb   = b_q[14:10];
  assign ma   = (ea == 5'd0) ? 12'd0 : {2'b01, a_q[9:0]};
  assign mb   = (eb == 5'd0) ? 12'd0 : {2'b01, b_q[9:0]};
  assign swap = (eb > ea) || ((eb == ea) && (mb > ma));
  assign ex_u = swap ? eb : ea;
  assign ey_u = swap ? ea : eb;
  assign diff = ex_u - ey_u;
  assign d_un = (diff > CAP5) ? CAP4 : diff[3:0];

  // X is the larger magnitude, so subtraction never goes negative
  assign sum_m = (sx_q == sy_q) ? (mx_q + my_q) : (mx_q - my_q);

  // Zero, overflow saturation and underflow checked on the wide exponent
  always_comb begin
    if (mx_q == 12'd0)           packed_res = 16'h0000;
    else if (ex_q > 7'sd31)      packed_res = {sx_q, 5'h1F, 10'h3FF};
    else if (ex_q < 7'sd1)       packed_res = 16'h0000;
    else                         packed_res = {sx_q, ex_q[4:0], mx_q[9:0]};
  end

  function automatic logic need_norm(input logic [MW-1:0] m);
    return m[11] | (~m[10] & (m != 12'd0));
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    ex_d      = ex_q;
    mx_d      = mx_q;
    my_d      = my_q;
    d_d       = d_q;
    res_lo_d  = res_lo_q;
    wr_data_d = wr_data_q;
    addr_d    = addr_q;

    case (state_q)
      IDLE, DONE: if (bus.start) state_d = RD0;
      RD0: state_d = RD1;
      RD1: begin a_d[15:8] = bus.mem_rd_data; state_d = RD2; end
      RD2: begin a_d[7:0]  = bus.mem_rd_data; state_d = RD3; end
      RD3: begin b_d[15:8] = bus.mem_rd_data; state_d = RDW; end
      RDW: begin b_d[7:0]  = bus.mem_rd_data; state_d = UNPACK; end
      UNPACK: begin
        sx_d    = swap ? b_q[15] : a_q[15];
        sy_d    = swap ? a_q[15] : b_q[15];
        ex_d    = {2'b00, ex_u};
        mx_d    = swap ? mb : ma;
        my_d    = swap ? ma : mb;
        d_d     = d_un;
        state_d = (d_un == 4'd0) ? ADD : ALIGN;
      end
      ALIGN: begin
        my_d = my_q >> 1;
        d_d  = d_q - 4'd1;
        if (d_q == 4'd1) state_d = ADD;
      end
      ADD: begin
        mx_d    = sum_m;
        state_d = need_norm(sum_m) ? NORM : PACK;
      end
      NORM: begin
        if (mx_q[11]) begin
          mx_d = mx_q >> 1;
          ex_d = ex_q + 7'sd1;
        end else begin
          mx_d = mx_q << 1;
          ex_d = ex_q - 7'sd1;
        end
        state_d = need_norm(mx_d) ? NORM : PACK;
      end
      PACK: begin
        wr_data_d = packed_res[15:8];
        res_lo_d  = packed_res[7:0];
        state_d   = WRH;
      end
      WRH: begin wr_data_d = res_lo_q; state_d = WRL; end
      WRL: state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Outputs track the state being entered so they are valid throughout it
    busy_d  = !(state_d inside {IDLE, DONE});
    done_d  = (state_d == DONE);
    wr_en_d = (state_d inside {WRH, WRL});
    case (state_d)
      RD0:     addr_d = BASE8;
      RD1:     addr_d = BASE8 + 8'd1;
      RD2:     addr_d = BASE8 + 8'd2;
      RD3:     addr_d = BASE8 + 8'd3;
      WRH:     addr_d = BASE8 + 8'd4;
      WRL:     addr_d = BASE8 + 8'd5;
      default: addr_d = addr_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      ex_q      <= '0;
      mx_q      <= '0;
      my_q      <= '0;
      d_q       <= '0;
      res_lo_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      ex_q      <= ex_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      d_q       <= d_d;
      res_lo_q  <= res_lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_fp16_add_seq.sv
// Directed bench for fp16_add_seq with a registered-read byte memory model.
module tb_fp16_add_seq;

  localparam int unsigned OP = 128;

  logic clk = 1'b0;
  logic reset = 1'b1;
  fp16_add_seq_if bus();

  logic [7:0] mem [256];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = 8'd0;
  logic [7:0] ld_data = 8'd0;

  int checks = 0;
  int passed = 0;

  fp16_add_seq #(.OP_BASE(OP), .ALIGN_CAP(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Byte memory: DUT write has priority, bench preload otherwise
  always @(posedge clk) begin
    if (bus.mem_wr_en)  mem[bus.mem_addr] <= bus.mem_wr_data;
    else if (ld_en)     mem[ld_addr] <= ld_data;
    bus.mem_rd_data <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
  endtask

  task automatic load_op(input logic [15:0] a, input logic [15:0] b);
    load(8'(OP + 0), a[15:8]);
    load(8'(OP + 1), a[7:0]);
    load(8'(OP + 2), b[15:8]);
    load(8'(OP + 3), b[7:0]);
    load(8'(OP + 4), 8'hDE);
    load(8'(OP + 5), 8'hAD);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Pulses start, optionally re-pulses start while busy, and checks result,
  // latency and write-strobe count.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input int exp_lat, input int glitch_at);
    int cnt;
    int wr;
    bit got;
    logic [15:0] res;
    load_op(a, b);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    cnt = 0; wr = 0; got = 1'b0;
    while (!got && cnt < 100) begin
      bus.start = (glitch_at != 0 && cnt == glitch_at);
      @(posedge clk);
      #1;
      cnt++;
      if (bus.mem_wr_en) wr++;
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    res = {mem[OP + 4], mem[OP + 5]};
    chk({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
    chk({tag, "_result"}, 32'(res), 32'(exp_res));
    chk({tag, "_wr_cycles"}, 32'(wr), 32'd2);
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.mem_wr_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("same", 16'h1A04, 16'h1A04, 16'h1E04, 11, 0);
    run_op("align2", 16'h4A10, 16'h4204, 16'h4B91, 12, 5);
    run_op("sub", 16'h3C00, 16'hBA00, 16'h3400, 13, 0);
    run_op("cancel", 16'h4204, 16'hC204, 16'h0000, 10, 0);
    run_op("ovf", 16'h7E0F, 16'h7E04, 16'h7FFF, 11, 0);

    // Abort in ALIGN: start from DONE, reach ALIGN, then assert reset between edges
    load_op(16'h4A10, 16'h4204);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("align_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_wr_en", 32'(bus.mem_wr_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("after_rst", 16'h4A10, 16'h4204, 16'h4B91, 12, 0);
    run_op("b2b", 16'h3C00, 16'hBA00, 16'h3400, 13, 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
